// File: rtl/piso_nbit_tx.sv
// rtl/piso_nbit_tx.sv - parallel-in serial-out transmitter with valid/ready load and frame/done strobes
module piso_nbit_tx #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset_ah_in,
  input  logic [N-1:0] d_in,
  input  logic         load_in,
  output logic         ready_out,
  output logic         q_out,
  output logic         frame_out,
  output logic         done_out
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  sreg, sreg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  sreg_shifted;
  logic          last_bit;
  logic          accept;

  // Zero-filled shift in the configured direction so sreg is empty once a word has gone out.
  assign sreg_shifted = MSB_FIRST ? {sreg[N-2:0], 1'b0} : {1'b0, sreg[N-1:1]};

  assign last_bit  = (state == SHIFT) && (cnt == LAST_CNT);
  assign ready_out = (state == IDLE) || last_bit;
  assign accept    = load_in && ready_out;

  assign q_out     = MSB_FIRST ? sreg[N-1] : sreg[0];
  assign frame_out = (state == SHIFT);
  assign done_out  = last_bit;

  // State, shift register and bit counter; reset wins over any load.
  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: accept a word when ready, otherwise shift until the last bit.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          sreg_nxt  = d_in;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (accept) begin
          sreg_nxt = d_in;
          cnt_nxt  = '0;
        end else if (last_bit) begin
          state_nxt = IDLE;
          sreg_nxt  = sreg_shifted;
          cnt_nxt   = '0;
        end else begin
          sreg_nxt = sreg_shifted;
          cnt_nxt  = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        sreg_nxt  = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_nbit_tx.sv
// tb/tb_piso_nbit_tx.sv - directed vector bench for piso_nbit_tx
module tb_piso_nbit_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // N=4, LSB first
  logic       ld4 = 1'b0;
  logic [3:0] d4  = '0;
  logic       rdy4, q4, f4, dn4;
  // N=4, MSB first
  logic       ldm = 1'b0;
  logic [3:0] dm  = '0;
  logic       rdym, qm, fm, dnm;
  // N=8, LSB first
  logic       ld8 = 1'b0;
  logic [7:0] d8  = '0;
  logic       rdy8, q8, f8, dn8;

  piso_nbit_tx #(.N(4), .MSB_FIRST(1'b0)) dut4 (
    .clk(clk), .reset_ah_in(rst), .d_in(d4), .load_in(ld4),
    .ready_out(rdy4), .q_out(q4), .frame_out(f4), .done_out(dn4));

  piso_nbit_tx #(.N(4), .MSB_FIRST(1'b1)) dutm (
    .clk(clk), .reset_ah_in(rst), .d_in(dm), .load_in(ldm),
    .ready_out(rdym), .q_out(qm), .frame_out(fm), .done_out(dnm));

  piso_nbit_tx #(.N(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .reset_ah_in(rst), .d_in(d8), .load_in(ld8),
    .ready_out(rdy8), .q_out(q8), .frame_out(f8), .done_out(dn8));

  // Companion shift-right receiver on the N=4 LSB-first link.
  logic [3:0] rx = '0;
  always_ff @(posedge clk) begin
    if (f4) rx <= {q4, rx[3:1]};
  end

  typedef struct packed {
    logic       rst;
    logic       ld;
    logic [3:0] d;
    logic       q;
    logic       f;
    logic       dn;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  wm;
    logic [3:0]  exp_m;
    logic [7:0]  w1, w2;
    logic        eq, ef, ed;

    //            rst  ld   d     q    f    dn   rdy
    // reset
    tbl.push_back({1'b1,1'b0,4'h0,1'b0,1'b0,1'b0,1'b1});
    // single word 4'b1011 -> 1,1,0,1
    tbl.push_back({1'b0,1'b1,4'hB,1'b1,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b0,4'h0,1'b1,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b0,4'h0,1'b0,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,1'b1});
    tbl.push_back({1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b1});
    // back-to-back A then 5 -> 0,1,0,1,1,0,1,0
    tbl.push_back({1'b0,1'b1,4'hA,1'b0,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b1,4'h5,1'b1,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b1,4'h5,1'b0,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b1,4'h5,1'b1,1'b1,1'b1,1'b1});
    tbl.push_back({1'b0,1'b1,4'h5,1'b1,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b0,4'h0,1'b0,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b0,4'h0,1'b1,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b0,4'h0,1'b0,1'b1,1'b1,1'b1});
    tbl.push_back({1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b1});
    // ignored load of F during a 0 word
    tbl.push_back({1'b0,1'b1,4'h0,1'b0,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b1,4'hF,1'b0,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b0,4'h0,1'b0,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b0,4'h0,1'b0,1'b1,1'b1,1'b1});
    tbl.push_back({1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b1});
    // mid-frame reset at the second bit
    tbl.push_back({1'b0,1'b1,4'hB,1'b1,1'b1,1'b0,1'b0});
    tbl.push_back({1'b0,1'b0,4'h0,1'b1,1'b1,1'b0,1'b0});
    tbl.push_back({1'b1,1'b0,4'h0,1'b0,1'b0,1'b0,1'b1});
    tbl.push_back({1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b1});
    tbl.push_back({1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b1});
    // reset has priority over load
    tbl.push_back({1'b1,1'b1,4'hF,1'b0,1'b0,1'b0,1'b1});
    tbl.push_back({1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b1});

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      ld4 = tbl[i].ld;
      d4  = tbl[i].d;
      edge_then_sample();
      chk($sformatf("v%0d_q", i),     32'(q4),   32'(tbl[i].q));
      chk($sformatf("v%0d_frame", i), 32'(f4),   32'(tbl[i].f));
      chk($sformatf("v%0d_done", i),  32'(dn4),  32'(tbl[i].dn));
      chk($sformatf("v%0d_ready", i), 32'(rdy4), 32'(tbl[i].rdy));
    end
    @(negedge clk);
    rst = 1'b0;
    ld4 = 1'b0;

    // other instances idle after reset
    chk("msb_reset_ready", 32'(rdym), 32'd1);
    chk("msb_reset_frame", 32'(fm),   32'd0);
    chk("n8_reset_ready",  32'(rdy8), 32'd1);
    chk("n8_reset_q",      32'(q8),   32'd0);

    // receiver on the LSB-first link reassembles 4'b1011
    ld4 = 1'b1;
    d4  = 4'hB;
    edge_then_sample();
    @(negedge clk);
    ld4 = 1'b0;
    for (int i = 0; i < 4; i++) edge_then_sample();
    chk("rx_word", 32'(rx), 32'hB);
    chk("rx_idle_frame", 32'(f4), 32'd0);

    // MSB first: 4'b1011 -> 1,0,1,1
    wm = 4'b1011;
    @(negedge clk);
    ldm = 1'b1;
    dm  = wm;
    for (int i = 0; i < 5; i++) begin
      edge_then_sample();
      @(negedge clk);
      ldm = 1'b0;
      exp_m = (i < 4) ? wm : 4'h0;
      chk($sformatf("msb_q%0d", i),    32'(qm),  32'((i < 4) ? exp_m[3 - (i & 3)] : 1'b0));
      chk($sformatf("msb_f%0d", i),    32'(fm),  32'(i < 4));
      chk($sformatf("msb_done%0d", i), 32'(dnm), 32'(i == 3));
    end

    // N=8: 8'h81, one idle gap, then 8'h7E
    w1 = 8'h81;
    w2 = 8'h7E;
    for (int s = 0; s < 18; s++) begin
      @(negedge clk);
      ld8 = (s == 0) || (s == 9);
      d8  = (s == 0) ? w1 : ((s == 9) ? w2 : 8'hFF);
      edge_then_sample();
      if (s < 8) begin
        eq = w1[s]; ef = 1'b1; ed = (s == 7);
      end else if (s == 8) begin
        eq = 1'b0; ef = 1'b0; ed = 1'b0;
      end else if (s < 17) begin
        eq = w2[s - 9]; ef = 1'b1; ed = (s == 16);
      end else begin
        eq = 1'b0; ef = 1'b0; ed = 1'b0;
      end
      chk($sformatf("n8_q%0d", s),    32'(q8),  32'(eq));
      chk($sformatf("n8_f%0d", s),    32'(f8),  32'(ef));
      chk($sformatf("n8_done%0d", s), 32'(dn8), 32'(ed));
    end
    @(negedge clk);
    ld8 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
